// File: rtl/rr_sel_arbiter_pkg.sv
// Shared widths and state encoding for the
// round-robin select arbiter ahead of the pr_en mux.
package rr_sel_arbiter_pkg;

  localparam int PR_EN_SEL_W = 2;
  localparam int PR_EN_NREQ  = 4;
  localparam int CNT_W       = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_sel_arbiter_pick4.sv
// Rotating 4-way priority pick: search last+1..last+4,
// so the previous owner has the lowest priority.
module rr_pick4
  import rr_sel_arbiter_pkg::*;
(
  input  logic [PR_EN_NREQ-1:0]  req,
  input  logic [PR_EN_SEL_W-1:0] last,
  output logic [PR_EN_SEL_W-1:0] pick,
  output logic                   any
);

  // first asserted request after last, wrapping mod 4
  always_comb begin
    logic [PR_EN_SEL_W-1:0] idx;
    pick = last;
    any  = 1'b0;
    idx  = last;
    for (int k = 1; k <= PR_EN_NREQ; k++) begin
      idx = last + PR_EN_SEL_W'(k);
      if (!any && req[idx]) begin
        any  = 1'b1;
        pick = idx;
      end
    end
  end

endmodule

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter generating pr_en.sel plus a
// valid/ready handshake with bounded bursts per grant.
module rr_sel_arbiter
  import rr_sel_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PR_EN_NREQ-1:0]  req,
  input  logic                   out_ready,
  output logic [PR_EN_SEL_W-1:0] sel,
  output logic                   out_valid,
  output logic [PR_EN_NREQ-1:0]  ack,
  output logic                   busy
);

  localparam logic [CNT_W-1:0] LAST_BEAT =
    CNT_W'(MAX_BURST - 1);

  state_t                 state, state_nx;
  logic [PR_EN_SEL_W-1:0] sel_nx;
  logic [CNT_W-1:0]       cnt, cnt_nx;
  logic [PR_EN_SEL_W-1:0] pick;
  logic                   any;
  logic                   xfer;
  logic                   rel;

  rr_pick4 u_pick (
    .req  (req),
    .last (sel),
    .pick (pick),
    .any  (any)
  );

  // handshake outputs; reset cycle never acknowledges
  always_comb begin
    out_valid = (state == ST_GRANT) & req[sel];
    xfer      = out_valid & out_ready & ~rst;
    ack       = xfer ? (PR_EN_NREQ'(1) << sel) : '0;
    busy      = (state == ST_GRANT);
    rel       = ~req[sel] |
                (xfer & (cnt == LAST_BEAT));
  end

  // next-state: grant, burst count and rotation
  always_comb begin
    state_nx = state;
    sel_nx   = sel;
    cnt_nx   = cnt;
    unique case (state)
      ST_IDLE: begin
        if (any) begin
          sel_nx   = pick;
          cnt_nx   = '0;
          state_nx = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (rel) begin
          if (any) begin
            sel_nx = pick;
            cnt_nx = '0;
          end else begin
            state_nx = ST_IDLE;
          end
        end else if (xfer) begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // state register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      sel   <= 2'd3;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      sel   <= sel_nx;
      cnt   <= cnt_nx;
    end
  end

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Randomized bench for rr_sel_arbiter: two instances
// (MAX_BURST 4 and 1) against a behavioural model.
module tb_rr_sel_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       rdy;

  logic [1:0] sel_o [2];
  logic       vld_o [2];
  logic [3:0] ack_o [2];
  logic       bsy_o [2];

  int nvec = 0;
  int nerr = 0;

  int mb    [2] = '{4, 1};
  bit m_g   [2];
  int m_own [2];
  int m_b   [2];

  always #5 clk = ~clk;

  rr_sel_arbiter #(.MAX_BURST(4)) u_d4 (
    .clk(clk), .rst(rst), .req(req),
    .out_ready(rdy), .sel(sel_o[0]),
    .out_valid(vld_o[0]), .ack(ack_o[0]),
    .busy(bsy_o[0])
  );

  rr_sel_arbiter #(.MAX_BURST(1)) u_d1 (
    .clk(clk), .rst(rst), .req(req),
    .out_ready(rdy), .sel(sel_o[1]),
    .out_valid(vld_o[1]), .ack(ack_o[1]),
    .busy(bsy_o[1])
  );

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s @%0t got %0h want %0h",
               tag, $time, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] r,
                                 input int last);
    for (int k = 1; k <= 4; k++)
      if (r[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  function automatic bit m_xfer(input int d);
    return m_g[d] && req[m_own[d]] && rdy && !rst;
  endfunction

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      bit       xf;
      bit       v;
      logic [3:0] a;
      v  = m_g[d] && req[m_own[d]];
      xf = m_xfer(d);
      a  = xf ? 4'(1 << m_own[d]) : 4'd0;
      chk($sformatf("sel%0d", d), 8'(sel_o[d]),
          8'(m_own[d]));
      chk($sformatf("valid%0d", d), 8'(vld_o[d]),
          8'(v));
      chk($sformatf("ack%0d", d), 8'(ack_o[d]), 8'(a));
      chk($sformatf("busy%0d", d), 8'(bsy_o[d]),
          8'(m_g[d]));
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      bit xf;
      int w;
      xf = m_xfer(d);
      if (rst) begin
        m_g[d]   = 1'b0;
        m_own[d] = 3;
        m_b[d]   = 0;
      end else if (!m_g[d]) begin
        w = rr_pick(req, m_own[d]);
        if (w >= 0) begin
          m_g[d]   = 1'b1;
          m_own[d] = w;
          m_b[d]   = 0;
        end
      end else begin
        if (xf) m_b[d]++;
        if (!req[m_own[d]] || (xf && m_b[d] == mb[d])) begin
          w = rr_pick(req, m_own[d]);
          if (w >= 0) begin
            m_own[d] = w;
            m_b[d]   = 0;
          end else begin
            m_g[d] = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic cycle(input bit r,
                       input logic [3:0] q,
                       input bit o);
    @(negedge clk);
    rst = r;
    req = q;
    rdy = o;
    #1;
    compare_all();
    @(posedge clk);
    model_step();
  endtask

  initial begin
    logic [3:0] rq;
    rst = 1'b1;
    req = 4'd0;
    rdy = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_g[d]   = 1'b0;
      m_own[d] = 3;
      m_b[d]   = 0;
    end
    @(posedge clk);
    cycle(1'b1, 4'd0, 1'b0);
    cycle(1'b0, 4'd0, 1'b0);

    for (int i = 0; i < 36; i++)
      cycle(1'b0, 4'b1111, 1'b1);
    cycle(1'b1, 4'b1111, 1'b1);
    for (int i = 0; i < 12; i++)
      cycle(1'b0, 4'b0100, 1'b1);
    for (int i = 0; i < 20; i++)
      cycle(1'b0, 4'b0011, 1'(i % 2 == 0));
    cycle(1'b0, 4'b1010, 1'b0);
    cycle(1'b0, 4'b1000, 1'b0);
    for (int i = 0; i < 8; i++)
      cycle(1'b0, 4'b1001, 1'b1);

    rq = 4'd0;
    for (int i = 0; i < 2000; i++) begin
      for (int b = 0; b < 4; b++) begin
        if (rq[b]) begin
          if ($urandom_range(5) == 0) rq[b] = 1'b0;
        end else if ($urandom_range(2) == 0) begin
          rq[b] = 1'b1;
        end
      end
      cycle(1'($urandom_range(63) == 0), rq,
            1'($urandom_range(3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
